// File: rtl/down_cntr_pkg.sv
// Shared types and helpers for the down-counter scheduler.
// Holds the FSM encoding and the round-robin pick.
package down_cntr_pkg;

  localparam int DEF_CW  = 4;
  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } pick_t;

  // First set bit at or after last+1, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int                 n,
    input int                 last
  );
    pick_t r;
    int    j;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        j = (last + k) % n;
        if (!r.valid && req[5'(j)]) begin
          r.valid = 1'b1;
          r.idx   = 5'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/down_cntr_sched_if.sv
// Requester-side bundle of the down-counter scheduler.
// The scheduler owns grant/done/busy/cnt.
interface down_cntr_sched_if
  import down_cntr_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CW    = DEF_CW
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*CW-1:0] load_val;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic [CW-1:0]       cnt;

  modport master (
    output req,
    output load_val,
    input  grant,
    input  done,
    input  busy,
    input  cnt
  );

  modport slave (
    input  req,
    input  load_val,
    output grant,
    output done,
    output busy,
    output cnt
  );

endinterface

// File: rtl/down_cntr_core.sv
// Shared down-counter datapath: load wins over enable,
// and enable stops decrementing once the value is zero.
module down_cntr_core
  import down_cntr_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en && (q != '0)) begin
      q <= q - CW'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/down_cntr_sched.sv
// Round-robin owner of one down-counter: grants a requester,
// loads its value, counts to zero and pulses its done.
module down_cntr_sched
  import down_cntr_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CW    = DEF_CW
) (
  input logic              clk,
  input logic              rst,
  down_cntr_sched_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             own_req;
  logic             load;
  logic             en;
  logic             zero;
  pick_t            pk;

  assign pk      = rr_pick(MAX_REQ'(bus.req), N_REQ,
                           int'(last));
  assign own_req = bus.req[idx];
  assign cnt_d   = bus.load_val[int'(idx)*CW +: CW];

  // Counter only moves while the owner still holds req.
  assign load = (state == S_LOAD) && own_req;
  assign en   = (state == S_COUNT) && own_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      last    <= LAST_RST;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (pk.valid) begin
            idx     <= IW'(pk.idx);
            grant_q <= N_REQ'(1) << pk.idx;
            busy_q  <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD, S_COUNT: begin
          if (!own_req) begin
            state   <= S_IDLE;
            last    <= idx;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (state == S_LOAD) begin
            state <= S_COUNT;
          end else if (zero) begin
            state  <= S_DONE;
            done_q <= grant_q;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          last    <= idx;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  down_cntr_core #(
    .CW (CW)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (en),
    .d    (cnt_d),
    .q    (cnt_q),
    .zero (zero)
  );

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_down_cntr_sched.sv
// Bench for down_cntr_sched: vector table, directed corner
// sequences and random traffic against a timeline model.
module tb_down_cntr_sched;

  localparam int N  = 4;
  localparam int CW = 4;

  logic clk;
  logic rst;

  down_cntr_sched_if #(.N_REQ(N), .CW(CW)) bus ();

  down_cntr_sched #(
    .N_REQ (N),
    .CW    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  // Model: service seen as a timeline of k cycles since grant.
  // k=1 load, k=2..V+2 counting V..0, k=V+3 done, then idle.
  bit m_busy;
  int m_owner;
  int m_k;
  int m_v;
  int m_last;
  int m_cnt;

  task automatic model_edge();
    bit dropped;
    if (!rst) begin
      m_busy = 0;
      m_last = N - 1;
      m_cnt  = 0;
      m_k    = 0;
    end else if (!m_busy) begin
      for (int s = 1; s <= N; s++) begin
        int j;
        j = (m_last + s) % N;
        if (bus.req[j]) begin
          m_busy  = 1;
          m_owner = j;
          m_k     = 1;
          break;
        end
      end
    end else begin
      dropped = !bus.req[m_owner];
      if (m_k == 1) begin
        if (dropped) begin
          m_busy = 0;
          m_last = m_owner;
        end else begin
          m_v   = int'((bus.load_val >> (CW*m_owner)) & 16'hF);
          m_cnt = m_v;
          m_k   = 2;
        end
      end else if (m_k <= m_v + 2) begin
        if (dropped) begin
          m_busy = 0;
          m_last = m_owner;
        end else begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          m_k = m_k + 1;
        end
      end else begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    logic [3:0] ed;
    @(posedge clk);
    model_edge();
    #1;
    eg = m_busy ? oh(m_owner) : 4'b0000;
    ed = (m_busy && m_k >= 2 && m_k == m_v + 3) ?
         oh(m_owner) : 4'b0000;
    chk("model_grant", 32'(bus.grant), 32'(eg));
    chk("model_done", 32'(bus.done), 32'(ed));
    chk("model_busy", 32'(bus.busy), 32'(m_busy));
    chk("model_cnt", 32'(bus.cnt), 32'(m_cnt));
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [15:0] lv;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl[18];

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b0;
    bus.req      = '0;
    bus.load_val = '0;

    // Reset with all requests up, then index 0 (V=2),
    // then requester 1 with V=5 changed after its load.
    for (int i = 0; i < 3; i++)
      tbl[i] = '{1'b0, 4'hF, 16'h2222, 4'h0, 4'h0, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 4'hF, 16'h2222, 4'h1, 4'h0, 1'b1, 4'd0};
    tbl[4]  = '{1'b1, 4'h1, 16'h2222, 4'h1, 4'h0, 1'b1, 4'd2};
    tbl[5]  = '{1'b1, 4'h1, 16'h2222, 4'h1, 4'h0, 1'b1, 4'd1};
    tbl[6]  = '{1'b1, 4'h1, 16'h2222, 4'h1, 4'h0, 1'b1, 4'd0};
    tbl[7]  = '{1'b1, 4'h1, 16'h2222, 4'h1, 4'h1, 1'b1, 4'd0};
    tbl[8]  = '{1'b1, 4'h0, 16'h2222, 4'h0, 4'h0, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 4'h2, 16'h0050, 4'h2, 4'h0, 1'b1, 4'd0};
    tbl[10] = '{1'b1, 4'h2, 16'h0050, 4'h2, 4'h0, 1'b1, 4'd5};
    for (int i = 11; i < 16; i++)
      tbl[i] = '{1'b1, 4'h2, 16'h00F0, 4'h2, 4'h0, 1'b1,
                 4'(15 - i)};
    tbl[16] = '{1'b1, 4'h2, 16'h00F0, 4'h2, 4'h2, 1'b1, 4'd0};
    tbl[17] = '{1'b1, 4'h0, 16'h00F0, 4'h0, 4'h0, 1'b0, 4'd0};

    for (int i = 0; i < 18; i++) begin
      rst          = tbl[i].r;
      bus.req      = tbl[i].rq;
      bus.load_val = tbl[i].lv;
      step();
      chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tbl[i].d));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].b));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.cnt), 32'(tbl[i].c));
    end

    // Zero load on requester 0.
    bus.req      = 4'b0001;
    bus.load_val = 16'h0000;
    step();
    chk("zero_grant", 32'(bus.grant), 32'(4'b0001));
    step();
    chk("zero_cnt_t2", 32'(bus.cnt), 0);
    chk("zero_nodone_t2", 32'(bus.done), 0);
    step();
    chk("zero_done_t3", 32'(bus.done), 32'(4'b0001));
    chk("zero_cnt_t3", 32'(bus.cnt), 0);
    bus.req = '0;
    step();
    chk("zero_idle", 32'(bus.busy), 0);

    // Round-robin with all four held, V=2 each.
    rst = 1'b0;
    step();
    rst          = 1'b1;
    bus.req      = 4'hF;
    bus.load_val = 16'h2222;
    for (int s = 0; s < 5; s++) begin
      int nd;
      logic [3:0] dacc;
      nd   = 0;
      dacc = '0;
      for (int k = 1; k <= 6; k++) begin
        if (s == 4 && k == 6) bus.req = '0;
        step();
        if (k == 1)
          chk($sformatf("rr%0d_grant", s), 32'(bus.grant),
              32'(oh(s % 4)));
        if (k == 6)
          chk($sformatf("rr%0d_idle", s), 32'(bus.busy), 0);
        nd   = nd + $countones(bus.done);
        dacc = dacc | bus.done;
      end
      chk($sformatf("rr%0d_ndone", s), nd, 1);
      chk($sformatf("rr%0d_dwho", s), 32'(dacc), 32'(oh(s % 4)));
    end

    // Abort: requester 2 (V=9) drops at cnt 6, 3 waits.
    bus.req      = 4'b1100;
    bus.load_val = 16'h3900;
    step();
    chk("ab_grant2", 32'(bus.grant), 32'(4'b0100));
    for (int j = 0; j < 4; j++) begin
      step();
      chk("ab_cnt", 32'(bus.cnt), 32'(9 - j));
    end
    bus.req = 4'b1000;
    step();
    chk("ab_idle_busy", 32'(bus.busy), 0);
    chk("ab_idle_grant", 32'(bus.grant), 0);
    chk("ab_hold_cnt", 32'(bus.cnt), 6);
    chk("ab_no_done", 32'(bus.done), 0);
    step();
    chk("ab_grant3", 32'(bus.grant), 32'(4'b1000));
    chk("ab_load_cnt", 32'(bus.cnt), 6);
    begin
      int n;
      int d2;
      int d3;
      n  = 0;
      d2 = 0;
      d3 = 0;
      while (bus.busy && n < 20) begin
        step();
        n++;
        if (bus.done[3]) begin
          d3++;
          bus.req = '0;
        end
        if (bus.done[2]) d2++;
      end
      chk("ab_bound", 32'(n < 20), 1);
      chk("ab_done3", d3, 1);
      chk("ab_done2", d2, 0);
    end

    // Reset mid-count on requester 0 (V=7) at cnt 3.
    bus.req      = 4'b0001;
    bus.load_val = 16'h0007;
    step();
    begin
      int n;
      n = 0;
      while (bus.cnt != 4'd3 && n < 20) begin
        step();
        n++;
      end
      chk("rm_bound", 32'(n < 20), 1);
    end
    rst = 1'b0;
    step();
    chk("rm_cnt", 32'(bus.cnt), 0);
    chk("rm_grant", 32'(bus.grant), 0);
    chk("rm_busy", 32'(bus.busy), 0);
    chk("rm_done", 32'(bus.done), 0);
    rst     = 1'b1;
    bus.req = 4'b1010;
    step();
    chk("rm_regrant", 32'(bus.grant), 32'(4'b0010));
    bus.req = '0;
    step();
    chk("rm_abort_load", 32'(bus.busy), 0);

    // Random traffic, occasional drops and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        int b;
        b = int'($urandom_range(3));
        bus.req[b] = ~bus.req[b];
      end
      bus.load_val = 16'($urandom);
      rst = ($urandom_range(99) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
